// File: rtl/flatten_stream_if.sv
// flatten_stream_if: the flattener's two buses, the feature-map buffer read port and the
// valid/ready output stream toward the dense layer. The master side belongs to flatten_stream.
interface flatten_stream_if #(
  parameter int DATA_W = 8,
  parameter int IDX_W  = 4,
  parameter int FEAT_W = 1,
  parameter int ROW_W  = 1,
  parameter int COL_W  = 1
);
  // Buffer read port: address and strobe out, data back one cycle after rd_en
  logic              rd_en;
  logic [FEAT_W-1:0] rd_feature;
  logic [ROW_W-1:0]  rd_row;
  logic [COL_W-1:0]  rd_col;
  logic [DATA_W-1:0] rd_data;

  // Output stream
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [IDX_W-1:0]  out_index;
  logic              out_last;

  modport master (
    output rd_en, rd_feature, rd_row, rd_col,
    input  rd_data,
    output out_valid, out_data, out_index, out_last,
    input  out_ready
  );

  modport slave (
    input  rd_en, rd_feature, rd_row, rd_col,
    output rd_data,
    input  out_valid, out_data, out_index, out_last,
    output out_ready
  );
endinterface

// File: rtl/flatten_stream.sv
// flatten_stream: walks a pooled feature map (F x H x W) through a one-cycle-latency buffer
// read port and emits the elements as a 1-D valid/ready stream, in CHW or HWC order.
// A 2-entry skid FIFO absorbs the read latency so backpressure never loses an element.
// Optional feature: define FLATTEN_RELU_EN to clamp negative elements to zero at the output.
module flatten_stream #(
  parameter int NUM_FEATURES           = 10,
  parameter int POOLED_HEIGHT          = 10,
  parameter int POOLED_WIDTH           = 10,
  parameter int CONVOLUTION_DATA_WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  output logic             busy,
  output logic             done,
  flatten_stream_if.master bus
);

  localparam int FLATTENED_LENGTH = NUM_FEATURES * POOLED_HEIGHT * POOLED_WIDTH;
  localparam int IDX_W  = (FLATTENED_LENGTH > 1) ? $clog2(FLATTENED_LENGTH) : 1;
  localparam int FEAT_W = (NUM_FEATURES > 1)  ? $clog2(NUM_FEATURES)  : 1;
  localparam int ROW_W  = (POOLED_HEIGHT > 1) ? $clog2(POOLED_HEIGHT) : 1;
  localparam int COL_W  = (POOLED_WIDTH > 1)  ? $clog2(POOLED_WIDTH)  : 1;
  localparam int DW     = CONVOLUTION_DATA_WIDTH;

  localparam logic [FEAT_W-1:0] FEAT_MAX = FEAT_W'(NUM_FEATURES - 1);
  localparam logic [ROW_W-1:0]  ROW_MAX  = ROW_W'(POOLED_HEIGHT - 1);
  localparam logic [COL_W-1:0]  COL_MAX  = COL_W'(POOLED_WIDTH - 1);
  localparam logic [IDX_W-1:0]  IDX_MAX  = IDX_W'(FLATTENED_LENGTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t            state_q;
  logic              mode_q;
  logic              busy_q;
  logic              done_q;

  logic [FEAT_W-1:0] feat_q, feat_d;
  logic [ROW_W-1:0]  row_q,  row_d;
  logic [COL_W-1:0]  col_q,  col_d;
  logic              in_flight_q;

  logic [1:0]        fifo_count_q, fifo_count_d;
  logic [DW-1:0]     slot0_q, slot0_d;
  logic [DW-1:0]     slot1_q, slot1_d;
  logic [IDX_W-1:0]  idx_q, idx_d;

  logic              out_valid;
  logic              out_last;
  logic              push;
  logic              pop;
  logic [2:0]        occupancy;
  logic              rd_space;
  logic              issue_start;
  logic              rd_en;
  logic              mode_eff;
  logic              feat_end, row_end, col_end, last_read;
  logic [DW-1:0]     out_elem;

  // ---------------------------------------------------------------------------
  // Read issue control
  // ---------------------------------------------------------------------------
  assign out_valid = (fifo_count_q != 2'd0);
  assign out_last  = (idx_q == IDX_MAX);
  assign pop       = out_valid && bus.out_ready;
  assign push      = in_flight_q;

  // FIFO level after this cycle's pop and pending push; a read issued now lands one edge
  // later, so it is safe only if that level leaves a free slot even if the stream then stalls.
  assign occupancy   = {1'b0, fifo_count_q} - {2'b00, pop} + {2'b00, in_flight_q};
  assign rd_space    = (occupancy < 3'd2);
  // The first read goes out in the start cycle itself so data reaches the stream two
  // cycles after start; the FIFO is always empty in IDLE, so no space check is needed.
  assign issue_start = (state_q == S_IDLE) && start;
  assign rd_en       = issue_start || ((state_q == S_RUN) && rd_space);

  // The walk order for the very first read is taken straight from the mode input
  assign mode_eff  = (state_q == S_IDLE) ? mode : mode_q;
  assign feat_end  = (feat_q == FEAT_MAX);
  assign row_end   = (row_q  == ROW_MAX);
  assign col_end   = (col_q  == COL_MAX);
  assign last_read = feat_end && row_end && col_end;

  // Next read address: nested counters, innermost dimension chosen by the walk order
  always_comb begin
    // NOTE: every variable gets its default first, so no path can leave it unassigned
    // and infer a latch.
    feat_d = feat_q;
    row_d  = row_q;
    col_d  = col_q;
    if (rd_en) begin
      if (!mode_eff) begin
        // CHW: col fastest, then row, then feature
        if (!col_end) begin
          col_d = col_q + 1'b1;
        end else begin
          col_d = '0;
          if (!row_end) begin
            row_d = row_q + 1'b1;
          end else begin
            row_d  = '0;
            feat_d = feat_end ? '0 : feat_q + 1'b1;
          end
        end
      end else begin
        // HWC: feature fastest, then col, then row
        if (!feat_end) begin
          feat_d = feat_q + 1'b1;
        end else begin
          feat_d = '0;
          if (!col_end) begin
            col_d = col_q + 1'b1;
          end else begin
            col_d = '0;
            row_d = row_end ? '0 : row_q + 1'b1;
          end
        end
      end
    end
  end

  // Address counters and the one-cycle read-latency tracker
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values, independent of statement order.
    if (!rst_n) begin
      feat_q      <= '0;
      row_q       <= '0;
      col_q       <= '0;
      in_flight_q <= 1'b0;
    end else begin
      feat_q      <= feat_d;
      row_q       <= row_d;
      col_q       <= col_d;
      in_flight_q <= rd_en;
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM with registered busy/done
  // ---------------------------------------------------------------------------
  // Sequences a run: issue reads, wait for the last element to leave, pulse done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      mode_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            mode_q  <= mode;
            busy_q  <= 1'b1;
            // A 1-element map has already issued its only read in this cycle
            state_q <= last_read ? S_DRAIN : S_RUN;
          end
        end
        S_RUN: begin
          if (rd_en && last_read) begin
            state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          // Elements leave in read order, so the last index transferring ends the run
          if (pop && out_last) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // 2-entry skid FIFO; slot0 is always the head
  // ---------------------------------------------------------------------------
  // FIFO next state: push returning read data, pop on handshake, order preserved
  always_comb begin
    fifo_count_d = fifo_count_q;
    slot0_d      = slot0_q;
    slot1_d      = slot1_q;
    case ({push, pop})
      2'b10: begin
        if (fifo_count_q == 2'd0) slot0_d = bus.rd_data;
        else                      slot1_d = bus.rd_data;
        fifo_count_d = fifo_count_q + 2'd1;
      end
      2'b01: begin
        slot0_d      = slot1_q;
        fifo_count_d = fifo_count_q - 2'd1;
      end
      2'b11: begin
        if (fifo_count_q == 2'd1) begin
          slot0_d = bus.rd_data;
        end else begin
          slot0_d = slot1_q;
          slot1_d = bus.rd_data;
        end
      end
      default: ;
    endcase
  end

  // FIFO storage and the flattened-position counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_count_q <= 2'd0;
      // NOTE: the data slots are reset too; they drive out_data directly and must read 0
      // out of reset, which a larger RAM-style buffer would not need.
      slot0_q      <= '0;
      slot1_q      <= '0;
      idx_q        <= '0;
    end else begin
      fifo_count_q <= fifo_count_d;
      slot0_q      <= slot0_d;
      slot1_q      <= slot1_d;
      idx_q        <= idx_d;
    end
  end

  assign idx_d = pop ? (out_last ? '0 : idx_q + 1'b1) : idx_q;

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
`ifdef FLATTEN_RELU_EN
  assign out_elem = slot0_q[DW-1] ? '0 : slot0_q;
`else
  assign out_elem = slot0_q;
`endif

  assign bus.rd_en      = rd_en;
  assign bus.rd_feature = feat_q;
  assign bus.rd_row     = row_q;
  assign bus.rd_col     = col_q;
  assign bus.out_valid  = out_valid;
  assign bus.out_data   = out_elem;
  assign bus.out_index  = idx_q;
  assign bus.out_last   = out_valid && out_last;
  assign busy           = busy_q;
  assign done           = done_q;

endmodule
